// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes, FSM states, default base.
package dmem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/byte enables and load extract + sign/zero extend.
// Assumes DATA_WIDTH >= 32 so a word access fits in one memory row.
module dmem_lane_align import dmem_pkg::*; #(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH/8,
  localparam int OFFW       = $clog2(NB)
) (
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [OFFW-1:0]       offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [DATA_WIDTH-1:0] wlane,
  output logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [OFFW-1:0]       aoff;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign;
  int                    nbytes;

  // misaligned low bits are dropped, so a halfword/word always covers whole naturally aligned lanes
  always_comb begin
    aoff   = offset;
    nbytes = 1;
    case (size)
      SIZE_HALF: begin aoff[0] = 1'b0;     nbytes = 2; end
      SIZE_WORD: begin aoff[1:0] = 2'b00;  nbytes = 4; end
      default:   ;
    endcase
  end

  assign wlane   = wdata << {aoff, 3'b000};
  assign shifted = rword >> {aoff, 3'b000};

  always_comb begin
    case (size)
      SIZE_HALF: sign = shifted[15];
      SIZE_WORD: sign = shifted[31];
      default:   sign = shifted[7];
    endcase
  end

  always_comb begin
    be    = '0;
    rdata = '0;
    for (int i = 0; i < NB; i++)
      be[i] = (i >= int'(aoff)) && (i < int'(aoff) + nbytes);
    for (int i = 0; i < DATA_WIDTH; i++)
      rdata[i] = (i < nbytes*8) ? shifted[i] : (sign & ~is_unsigned);
  end
endmodule

// File: rtl/data_memory_be.sv
// Byte-enabled data memory with valid/ready handshake and configurable read latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module data_memory_be import dmem_pkg::*; #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int NB   = DATA_WIDTH/8;
  localparam int OFFW = $clog2(NB);
  localparam int AW   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  state_t                state, state_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic [31:0]           off, idx_full;
  logic [AW-1:0]         idx;
  logic                  err, accept;
  logic [DATA_WIDTH-1:0] rword, wlane, ext;
  logic [NB-1:0]         be;

  // 32-bit wrap makes below-base addresses land far above MEMORY_DEPTH
  assign off      = req_addr - BASE_ADDR;
  assign idx_full = off >> OFFW;
  assign idx      = idx_full[AW-1:0];
  assign rword    = mem[idx];

  always_comb begin
    err = (idx_full >= 32'(MEMORY_DEPTH)) || (req_size == SIZE_RSVD);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((req_size == SIZE_HALF && req_addr[0]) ||
        (req_size == SIZE_WORD && req_addr[1:0] != 2'b00))
      err = 1'b1;
`endif
  end

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .offset      (req_addr[OFFW-1:0]),
    .wdata       (req_wdata),
    .rword       (rword),
    .wlane       (wlane),
    .be          (be),
    .rdata       (ext)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        if (req_write || err || READ_LATENCY == 1) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 2'(READ_LATENCY - 1);
        end
      end
      WAIT: if (cnt == 2'd1) begin
        state_nxt = RESP;
        cnt_nxt   = 2'd0;
      end else begin
        cnt_nxt   = cnt - 2'd1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // response data is captured at accept so it stays stable through WAIT and a stalled RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_rdata <= (err || req_write) ? '0 : ext;
        rsp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && accept && req_write && !err)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wlane[b*8 +: 8];
  end
endmodule

// File: tb/tb_data_memory_be.sv
// Scoreboard bench for data_memory_be (READ_LATENCY = 3); honours DMEM_ALIGN_CHECK_EN.
module tb_data_memory_be;
  localparam int          DW    = 32;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  data_memory_be #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; int lat; } exp_t;
  exp_t       sb[$];
  logic [7:0] mm [DEPTH*4];
  int         n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // byte-array reference model
  function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    logic [31:0] off;
    logic [31:0] v;
    int n, a;
    off = addr - BASE;
    e = ((off >> 2) >= DEPTH) || (sz == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)) e = 1'b1;
`endif
    d = '0;
    if (!e) begin
      n = 1 << sz;
      a = int'(off) & ~(n - 1);
      if (w) begin
        for (int k = 0; k < n; k++) mm[a+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mm[a+k];
        if (!uns && v[8*n-1])
          for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        d = v;
      end
    end
  endfunction

  task automatic txn(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input int stall,
                     output logic [31:0] got, output logic gerr);
    exp_t e;
    int   lat;
    model(w, sz, uns, addr, wd, e.data, e.err);
    e.lat = (!w && !e.err) ? LAT : 1;
    sb.push_back(e);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = (stall == 0);
    chk("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    got  = rsp_rdata;
    gerr = rsp_err;
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", lat, e.lat);
    chk("rdata", got, e.data);
    chk("err", gerr, e.err);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", rsp_valid, 1);
      chk("hold_data", rsp_rdata, e.data);
      chk("hold_err", rsp_err, e.err);
      chk("hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_vld", rsp_valid, 0);
    chk("idle_rdy", req_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    reset = 1'b0; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", rsp_valid, 0);
    chk("rst_data", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdy", req_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // word store then latency-3 word load
    txn(1, 2'd2, 0, 32'h1001_0004, 32'hDEAD_BEEF, 0, d, e);
    txn(0, 2'd2, 0, 32'h1001_0004, 0, 0, d, e);
    chk("w_load", d, 32'hDEAD_BEEF);

    // byte store, signed/unsigned byte loads, merged word
    txn(1, 2'd0, 0, 32'h1001_0005, 32'h0000_0080, 0, d, e);
    txn(0, 2'd0, 0, 32'h1001_0005, 0, 0, d, e);
    chk("lb_signed", d, 32'hFFFF_FF80);
    txn(0, 2'd0, 1, 32'h1001_0005, 0, 0, d, e);
    chk("lb_unsigned", d, 32'h0000_0080);
    txn(0, 2'd2, 0, 32'h1001_0004, 0, 0, d, e);
    chk("lw_merged", d, 32'hDEAD_80EF);

    // out-of-range and reserved size
    txn(0, 2'd2, 0, 32'h1000_FFFC, 0, 0, d, e);
    chk("below_err", e, 1);
    txn(0, 2'd2, 0, BASE + 4*DEPTH, 0, 0, d, e);
    chk("above_err", e, 1);
    txn(1, 2'd2, 0, BASE + 4*DEPTH, 32'h5555_5555, 0, d, e);
    txn(0, 2'd3, 0, 32'h1001_0004, 0, 0, d, e);
    chk("rsvd_err", e, 1);
    txn(0, 2'd2, 0, 32'h1001_0004, 0, 0, d, e);
    chk("unchanged", d, 32'hDEAD_80EF);

    // misaligned halfword store
    txn(1, 2'd2, 0, 32'h1001_0000, 32'h1122_3344, 0, d, e);
    txn(1, 2'd1, 0, 32'h1001_0001, 32'h0000_AABB, 0, d, e);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", e, 1);
    txn(0, 2'd2, 0, 32'h1001_0000, 0, 0, d, e);
    chk("mis_nowrite", d, 32'h1122_3344);
`else
    chk("mis_err", e, 0);
    txn(0, 2'd2, 0, 32'h1001_0000, 0, 0, d, e);
    chk("mis_write", d, 32'h1122_AABB);
`endif

    // back-pressure: hold response for 5 cycles
    txn(0, 2'd2, 0, 32'h1001_0004, 0, 5, d, e);
    chk("stall_data", d, 32'hDEAD_80EF);

    // reset while a load is in WAIT
    req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h1001_0004;
    @(posedge clk); #1;
    req_valid = 0;
    chk("wait_vld", rsp_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstw_vld", rsp_valid, 0);
    chk("rstw_rdy", req_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstw_vld2", rsp_valid, 0);
    txn(0, 2'd2, 0, 32'h1001_0004, 0, 0, d, e);
    chk("rstw_keep", d, 32'hDEAD_80EF);

    // random traffic over the first 16 words
    for (int i = 0; i < 16; i++)
      txn(1, 2'd2, 0, BASE + 32'(4*i), $urandom, 0, d, e);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 15));
        1:       a = BASE - 32'($urandom_range(1, 8));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, $urandom_range(0, 2), d, e);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
